// File: rtl/div_unit_if.sv
// Divider request/result bundle.
// Optional macro DIV_BY_ZERO_TRAP_EN adds the div_by_zero result flag.
interface div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  signed_op;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
`ifdef DIV_BY_ZERO_TRAP_EN
  logic                  div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder
  );
`endif
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per clock.
// Optional macro DIV_BY_ZERO_TRAP_EN: a zero divisor bypasses the iterations
// and finishes one edge after start with quotient all-ones, remainder = dividend
// and div_by_zero pulsed alongside done.
//
// state | meaning
// IDLE  | waiting for start; operands sampled here only
// RUN   | one shift-subtract iteration per edge on the magnitudes
// FIX   | apply result signs, register outputs, pulse done
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input logic        clock,
  input logic        clear,
  div_unit_if.slave  bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] dvsr_q;
  logic [CW-1:0]         count;
  logic                  neg_quo;
  logic                  neg_rem;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] quotient_q;
  logic [DATA_WIDTH-1:0] remainder_q;
`ifdef DIV_BY_ZERO_TRAP_EN
  logic                  zero_q;
  logic                  dbz_q;
`endif

  logic [DATA_WIDTH:0]   partial;
  logic                  take;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] dvd_mag;
  logic [DATA_WIDTH-1:0] dvs_mag;
  logic                  dvd_neg;
  logic                  dvs_neg;

  // Operand magnitudes for the IDLE sample and the restoring-step datapath.
  // The partial remainder stays below the divisor, so the difference fits in
  // DATA_WIDTH bits once the compare has said the subtract is taken.
  always_comb begin
    dvd_neg  = bus.signed_op & bus.dividend[DATA_WIDTH-1];
    dvs_neg  = bus.signed_op & bus.divisor[DATA_WIDTH-1];
    dvd_mag  = dvd_neg ? ({DATA_WIDTH{1'b0}} - bus.dividend) : bus.dividend;
    dvs_mag  = dvs_neg ? ({DATA_WIDTH{1'b0}} - bus.divisor) : bus.divisor;
    partial  = {rem_q, quo_q[DATA_WIDTH-1]};
    take     = (partial >= {1'b0, dvsr_q});
    rem_next = take ? (partial[DATA_WIDTH-1:0] - dvsr_q) : partial[DATA_WIDTH-1:0];
  end

  // Sequencer: sample, iterate, sign-fix; every output is a register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      dvsr_q      <= '0;
      count       <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_BY_ZERO_TRAP_EN
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef DIV_BY_ZERO_TRAP_EN
      dbz_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            rem_q   <= '0;
            dvsr_q  <= dvs_mag;
            neg_quo <= dvd_neg ^ dvs_neg;
            neg_rem <= dvd_neg;
            count   <= CW'(DATA_WIDTH);
            busy_q  <= 1'b1;
`ifdef DIV_BY_ZERO_TRAP_EN
            // A trapped divide reports the raw dividend, so skip the magnitude.
            if (bus.divisor == '0) begin
              zero_q <= 1'b1;
              quo_q  <= bus.dividend;
              state  <= FIX;
            end else begin
              zero_q <= 1'b0;
              quo_q  <= dvd_mag;
              state  <= RUN;
            end
`else
            quo_q   <= dvd_mag;
            state   <= RUN;
`endif
          end
        end
        RUN: begin
          quo_q <= {quo_q[DATA_WIDTH-2:0], take};
          rem_q <= rem_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
`ifdef DIV_BY_ZERO_TRAP_EN
          if (zero_q) begin
            quotient_q  <= '1;
            remainder_q <= quo_q;
            dbz_q       <= 1'b1;
          end else begin
            quotient_q  <= neg_quo ? ({DATA_WIDTH{1'b0}} - quo_q) : quo_q;
            remainder_q <= neg_rem ? ({DATA_WIDTH{1'b0}} - rem_q) : rem_q;
          end
          zero_q <= 1'b0;
`else
          quotient_q  <= neg_quo ? ({DATA_WIDTH{1'b0}} - quo_q) : quo_q;
          remainder_q <= neg_rem ? ({DATA_WIDTH{1'b0}} - rem_q) : rem_q;
`endif
          count  <= '0;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
`ifdef DIV_BY_ZERO_TRAP_EN
  assign bus.div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with hand-computed quotient/remainder values.
module tb_div_unit;

  logic clock;
  logic clear;
  int   checks;
  int   errors;

  div_unit_if #(.DATA_WIDTH(32)) bus ();

  div_unit #(.DATA_WIDTH(32)) u_dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge, then scramble them.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.start     = 1'b1;
    bus.signed_op = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clock);
    #1;
    bus.start     = 1'b0;
    bus.signed_op = ~sgn;
    bus.dividend  = ~a;
    bus.divisor   = b + 32'd3;
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(input string tag, input int exp_lat);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clock);
      #1;
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    launch(sgn, a, b);
    wait_done(tag, 33);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
  endtask

  initial begin
    int done_cnt;
    checks        = 0;
    errors        = 0;
    clear         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    #12;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_q", bus.quotient, 32'd0);
    check("rst_r", bus.remainder, 32'd0);
    @(negedge clock);
    clear = 1'b1;

    // 100/7 unsigned, with busy/done timing around it
    launch(1'b0, 32'd100, 32'd7);
    check("u100_busy_run", {31'd0, bus.busy}, 32'd1);
    wait_done("u100", 33);
    check("u100_busy_done", {31'd0, bus.busy}, 32'd0);
    check("u100_q", bus.quotient, 32'd14);
    check("u100_r", bus.remainder, 32'd2);
    @(posedge clock);
    #1;
    check("u100_done_pulse", {31'd0, bus.done}, 32'd0);
    repeat (5) @(posedge clock);
    #1;
    check("u100_hold_q", bus.quotient, 32'd14);
    check("u100_hold_r", bus.remainder, 32'd2);

    run_op("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run_op("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
    run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_op("u_max_16", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15);
    run_op("u_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

`ifdef DIV_BY_ZERO_TRAP_EN
    launch(1'b0, 32'd55, 32'd0);
    wait_done("u55_0", 1);
    check("u55_0_dbz", {31'd0, bus.div_by_zero}, 32'd1);
    check("u55_0_q", bus.quotient, 32'hFFFF_FFFF);
    check("u55_0_r", bus.remainder, 32'd55);
`else
    run_op("u55_0", 1'b0, 32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55);
    run_op("s_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'd1, 32'hFFFF_FFF9);
`endif

    // start while busy is ignored; start in the done cycle is taken
    launch(1'b0, 32'd1000, 32'd10);
    repeat (9) @(posedge clock);
    @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(posedge clock);
    #1;
    bus.start    = 1'b0;
    wait_done("ign", 23);
    check("ign_q", bus.quotient, 32'd100);
    check("ign_r", bus.remainder, 32'd0);
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd77;
    bus.divisor   = 32'd5;
    @(posedge clock);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 32'd1;
    bus.divisor  = 32'd1;
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    check("b2b_hold_q", bus.quotient, 32'd100);
    wait_done("b2b", 33);
    check("b2b_q", bus.quotient, 32'd15);
    check("b2b_r", bus.remainder, 32'd2);

    // clear in the middle of a run
    launch(1'b0, 32'd1000, 32'd3);
    repeat (14) @(posedge clock);
    #2;
    clear = 1'b0;
    #1;
    check("clr_busy", {31'd0, bus.busy}, 32'd0);
    check("clr_done", {31'd0, bus.done}, 32'd0);
    check("clr_q", bus.quotient, 32'd0);
    check("clr_r", bus.remainder, 32'd0);
    @(negedge clock);
    clear = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    check("clr_no_done", 32'(done_cnt), 32'd0);
    run_op("post_clr", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
